accum_seq: RTL and testbench

// - Sequential accumulator controller that feeds the dw-bit adder/subtractor (addsub) and consumes its result.
// - Accepts one operation per valid/ready transaction and holds the running value in an accumulator register.
// - Drives addsub with dataa = accumulator and datab = operand, then writes the sum/difference back.
// - Reports the result plus carry/borrow, zero and sticky signed-overflow flags over a valid/ready output.

---
 rtl/accum_pkg.sv | 17 +
 rtl/addsub.sv | 36 +++
 rtl/accum_seq.sv | 127 ++++++++++++
 tb/tb_accum_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types for the accumulator controller: operation codes and FSM states.
package accum_pkg;

    typedef enum logic [1:0] {
        CLR  = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        SUB  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage : accum_pkg

// File: rtl/addsub.sv
// Combinational dw-bit adder/subtractor with carry/borrow and signed-overflow outputs.
module addsub #(
    parameter int dw = 8
) (
    input  logic [dw-1:0] dataa,
    input  logic [dw-1:0] datab,
    input  logic          add_sub,
    output logic [dw-1:0] result,
    output logic          carry,
    output logic          overflow
);

    logic [dw:0] sum_ext;
    logic [dw:0] diff_ext;

    assign sum_ext  = {1'b0, dataa} + {1'b0, datab};
    assign diff_ext = {1'b0, dataa} - {1'b0, datab};

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        result   = sum_ext[dw-1:0];
        carry    = 1'b0;
        overflow = 1'b0;
        if (add_sub) begin
            result   = sum_ext[dw-1:0];
            carry    = sum_ext[dw];
            overflow = (dataa[dw-1] == datab[dw-1]) && (sum_ext[dw-1] != dataa[dw-1]);
        end else begin
            result   = diff_ext[dw-1:0];
            // The extra borrow bit is set exactly when dataa < datab (unsigned).
            carry    = diff_ext[dw];
            overflow = (dataa[dw-1] != datab[dw-1]) && (diff_ext[dw-1] != dataa[dw-1]);
        end
    end

endmodule : addsub

// File: rtl/accum_seq.sv
// Sequential accumulator controller: one op per valid/ready transaction, result and
// sticky flags presented over a registered valid/ready output.
module accum_seq
    import accum_pkg::*;
#(
    parameter int dw = 8,
    parameter int cw = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [1:0]    op_code,
    input  logic [dw-1:0] op_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [dw-1:0] res_data,
    output logic          res_carry,
    output logic          res_zero,
    output logic          res_ovf,
    output logic [cw-1:0] op_count
);

    state_t        state_q;
    op_t           op_q;
    logic [dw-1:0] opnd_q;
    logic [dw-1:0] acc_q, acc_d;
    logic          carry_q, carry_d;
    logic          zero_q;
    logic          ovf_q, ovf_d;
    logic [cw-1:0] op_count_q;
    logic          op_ready_q;
    logic          res_valid_q;

    logic [dw-1:0] as_result;
    logic          as_carry;
    logic          as_ovf;

    addsub #(.dw(dw)) u_addsub (
        .dataa    (acc_q),
        .datab    (opnd_q),
        .add_sub  (op_q == ADD),
        .result   (as_result),
        .carry    (as_carry),
        .overflow (as_ovf)
    );

    // Next accumulator and flag values; only committed in EXEC.
    always_comb begin
        acc_d   = acc_q;
        carry_d = 1'b0;
        ovf_d   = ovf_q;
        case (op_q)
            CLR: begin
                acc_d = '0;
                ovf_d = 1'b0;
            end
            LOAD: acc_d = opnd_q;
            ADD, SUB: begin
                acc_d   = as_result;
                carry_d = as_carry;
                ovf_d   = ovf_q | as_ovf;
            end
            default: acc_d = acc_q;
        endcase
    end

    // NOTE: state is written with <= only, so every register samples pre-edge values
    // regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            op_count_q  <= '0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            // NOTE: op_q/opnd_q are deliberately not reset; IDLE always writes them
            // before EXEC reads them.
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_ready_q && op_valid) begin
                        op_q       <= op_t'(op_code);
                        opnd_q     <= op_data;
                        op_ready_q <= 1'b0;
                        state_q    <= EXEC;
                    end else begin
                        op_ready_q <= 1'b1;
                    end
                end
                EXEC: begin
                    acc_q       <= acc_d;
                    carry_q     <= carry_d;
                    zero_q      <= (acc_d == '0);
                    ovf_q       <= ovf_d;
                    op_count_q  <= op_count_q + 1'b1;
                    res_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        op_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    op_ready_q  <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign op_ready  = op_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = acc_q;
    assign res_carry = carry_q;
    assign res_zero  = zero_q;
    assign res_ovf   = ovf_q;
    assign op_count  = op_count_q;

endmodule : accum_seq

// File: tb/tb_accum_seq.sv
// Directed self-checking bench for accum_seq with an arithmetic reference model.
module tb_accum_seq;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [1:0]    op_code = 2'd0;
    logic [DW-1:0] op_data = '0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [DW-1:0] res_data;
    logic          res_carry;
    logic          res_zero;
    logic          res_ovf;
    logic [CW-1:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_acc   = 0;
    int m_carry = 0;
    int m_ovf   = 0;
    int m_count = 0;

    accum_seq #(.dw(DW), .cw(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_data   (op_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_zero  (res_zero),
        .res_ovf   (res_ovf),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    function automatic int to_signed8(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    // Apply one operation to the model using plain integer arithmetic.
    task automatic model_apply(input logic [1:0] code, input logic [7:0] data);
        int b, s, ss;
        b = int'(data);
        case (code)
            2'd0: begin m_acc = 0; m_carry = 0; m_ovf = 0; end
            2'd1: begin m_acc = b; m_carry = 0; end
            2'd2: begin
                s  = m_acc + b;
                ss = to_signed8(m_acc) + to_signed8(b);
                m_carry = (s > 255) ? 1 : 0;
                if (ss > 127 || ss < -128) m_ovf = 1;
                m_acc = s % 256;
            end
            default: begin
                s  = m_acc - b;
                ss = to_signed8(m_acc) - to_signed8(b);
                m_carry = (m_acc < b) ? 1 : 0;
                if (ss > 127 || ss < -128) m_ovf = 1;
                m_acc = (s + 256) % 256;
            end
        endcase
        m_count = (m_count + 1) % 256;
    endtask

    task automatic model_reset();
        m_acc = 0; m_carry = 0; m_ovf = 0; m_count = 0;
    endtask

    // Compare process: whenever a result is presented it must match the model.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && res_valid) begin
                logic [7:0] ea;
                ea = m_acc[7:0];
                check("cmp_data",  {24'd0, res_data}, {24'd0, ea});
                check("cmp_carry", {31'd0, res_carry}, m_carry);
                check("cmp_zero",  {31'd0, res_zero}, (m_acc == 0) ? 1 : 0);
                check("cmp_ovf",   {31'd0, res_ovf}, m_ovf);
                check("cmp_count", {24'd0, op_count}, m_count);
                check("cmp_ready_in_hold", {31'd0, op_ready}, 0);
            end
        end
    end

    // Issue one op and capture the first presented result.
    task automatic do_op(input logic [1:0] code, input logic [7:0] data,
                         output logic [7:0] d, output logic c, output logic z,
                         output logic o, output logic [7:0] cnt);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (op_ready) begin ok = 1; break; end
        end
        if (!ok) timeout_fail("wait_op_ready");
        op_valid = 1'b1;
        op_code  = code;
        op_data  = data;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        model_apply(code, data);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1; break; end
        end
        if (!ok) timeout_fail("wait_res_valid");
        d = res_data; c = res_carry; z = res_zero; o = res_ovf; cnt = op_count;
        if (res_ready) begin
            ok = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!res_valid) begin ok = 1; break; end
            end
            if (!ok) timeout_fail("wait_res_drop");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d, cnt;
        logic       c, z, o;

        // Reset, then two idle cycles
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_op_ready_low", {31'd0, op_ready}, 0);
        check("rst_res_valid",    {31'd0, res_valid}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_data",     {24'd0, res_data}, 32'h00);
        check("post_rst_valid",    {31'd0, res_valid}, 0);
        check("post_rst_op_ready", {31'd0, op_ready}, 1);
        check("post_rst_count",    {24'd0, op_count}, 0);

        // LOAD 05, ADD 03
        do_op(2'd1, 8'h05, d, c, z, o, cnt);
        check("load05_data", {24'd0, d}, 32'h05);
        do_op(2'd2, 8'h03, d, c, z, o, cnt);
        check("add03_data",  {24'd0, d}, 32'h08);
        check("add03_carry", {31'd0, c}, 0);
        check("add03_zero",  {31'd0, z}, 0);
        check("add03_ovf",   {31'd0, o}, 0);
        check("add03_count", {24'd0, cnt}, 2);

        // SUB 0A from 08, then ADD 02
        do_op(2'd3, 8'h0A, d, c, z, o, cnt);
        check("sub0a_data",   {24'd0, d}, 32'hFE);
        check("sub0a_borrow", {31'd0, c}, 1);
        check("sub0a_ovf",    {31'd0, o}, 0);
        do_op(2'd2, 8'h02, d, c, z, o, cnt);
        check("add02_data",  {24'd0, d}, 32'h00);
        check("add02_zero",  {31'd0, z}, 1);
        check("add02_carry", {31'd0, c}, 1);

        // Signed overflow and its stickiness, cleared by CLR
        do_op(2'd1, 8'h7F, d, c, z, o, cnt);
        do_op(2'd2, 8'h01, d, c, z, o, cnt);
        check("ovf_data", {24'd0, d}, 32'h80);
        check("ovf_set",  {31'd0, o}, 1);
        do_op(2'd2, 8'h01, d, c, z, o, cnt);
        check("ovf_sticky_data", {24'd0, d}, 32'h81);
        check("ovf_sticky",      {31'd0, o}, 1);
        do_op(2'd0, 8'hAA, d, c, z, o, cnt);
        check("clr_data",  {24'd0, d}, 32'h00);
        check("clr_ovf",   {31'd0, o}, 0);
        check("clr_count", {24'd0, cnt}, 8);

        // Backpressure: hold result for 5 cycles, op_valid pulse must be ignored
        res_ready = 1'b0;
        do_op(2'd2, 8'h04, d, c, z, o, cnt);
        check("bp_first_data", {24'd0, d}, 32'h04);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                op_valid = 1'b1; op_code = 2'd1; op_data = 8'h55;
            end else begin
                op_valid = 1'b0;
            end
            @(negedge clk);
            check("bp_valid",    {31'd0, res_valid}, 1);
            check("bp_data",     {24'd0, res_data}, 32'h04);
            check("bp_op_ready", {31'd0, op_ready}, 0);
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {31'd0, res_valid}, 0);
        check("bp_release_ready", {31'd0, op_ready}, 1);
        check("bp_count",         {24'd0, op_count}, 9);
        check("bp_data_kept",     {24'd0, res_data}, 32'h04);

        // Reset while ADD 10 is in EXEC
        @(negedge clk);
        op_valid = 1'b1; op_code = 2'd2; op_data = 8'h10;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        model_reset();
        check("rst_exec_data",  {24'd0, res_data}, 32'h00);
        check("rst_exec_count", {24'd0, op_count}, 0);
        check("rst_exec_valid", {31'd0, res_valid}, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_exec_no_result", {31'd0, res_valid}, 0);
        end
        check("rst_exec_ready", {31'd0, op_ready}, 1);

        // Normal operation resumes after the aborted op
        do_op(2'd2, 8'h10, d, c, z, o, cnt);
        check("resume_data",  {24'd0, d}, 32'h10);
        check("resume_count", {24'd0, cnt}, 1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_accum_seq
